ha_serial_add_seq: RTL and testbench



---
 rtl/ha_serial_add_seq.sv | 134 +++++++++++++
 tb/tb_ha_serial_add_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ha_serial_add_seq.sv
// Bit-serial WIDTH-bit adder built around one time-shared half-adder cell.
// Define HA_SEQ_SUB_EN to add the 'sub' port for subtraction (op_a - op_b).

module ha_serial_add_seq_ha (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;
endmodule

module ha_serial_add_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef HA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int unsigned IDXW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, P1, P2, FIN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opa_q, opb_q, result_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q, c1_q, part_q, cout_q;
  logic             ready_q, busy_q, done_q;

  logic ha_a, ha_b, ha_sum, ha_carry;
  logic carry_d;

  ha_serial_add_seq_ha u_ha (
    .a_i     (ha_a),
    .b_i     (ha_b),
    .sum_o   (ha_sum),
    .carry_o (ha_carry)
  );

  // P1 adds the operand bits; P2 folds in the running carry.
  always_comb begin
    ha_a = 1'b0;
    ha_b = 1'b0;
    if (state_q == P1) begin
      ha_a = opa_q[idx_q];
      ha_b = opb_q[idx_q];
    end else if (state_q == P2) begin
      ha_a = part_q;
      ha_b = carry_q;
    end
  end

  assign carry_d = c1_q | ha_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      c1_q     <= 1'b0;
      part_q   <= 1'b0;
      cout_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            opa_q   <= op_a;
`ifdef HA_SEQ_SUB_EN
            opb_q   <= sub ? ~op_b : op_b;
            carry_q <= sub ? 1'b1 : cin;
`else
            opb_q   <= op_b;
            carry_q <= cin;
`endif
            idx_q   <= '0;
            state_q <= P1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        P1: begin
          part_q  <= ha_sum;
          c1_q    <= ha_carry;
          state_q <= P2;
        end
        P2: begin
          result_q[idx_q] <= ha_sum;
          carry_q         <= carry_d;
          if (idx_q == IDXW'(WIDTH - 1)) begin
            cout_q  <= carry_d;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= P1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_ha_serial_add_seq.sv
// Scoreboard bench for ha_serial_add_seq (WIDTH=8); sub tests need HA_SEQ_SUB_EN.

module tb_ha_serial_add_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, cin;
  logic [7:0] op_a, op_b;
  logic       ready, busy, done, cout;
  logic [7:0] result;
`ifdef HA_SEQ_SUB_EN
  logic       sub = 1'b0;
`endif

  ha_serial_add_seq #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .cin    (cin),
`ifdef HA_SEQ_SUB_EN
    .sub    (sub),
`endif
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [8:0] expq[$];
  logic [8:0] last_val;
  bit         have_last = 0;
  bit         b2b = 0;
  bit         have_prev = 0;
  time        prev_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done, checks spacing and hold.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      have_last = 0;
      have_prev = 0;
    end else if (done) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no done at %0t", $time);
      end else begin
        e = expq.pop_front();
        check("sum", {23'd0, cout, result}, {23'd0, e});
      end
      if (b2b && have_prev) check("done_spacing", 32'(($time - prev_done) / 10), 18);
      prev_done = $time;
      have_prev = b2b;
      last_val  = {cout, result};
      have_last = 1;
    end else if (ready && have_last) begin
      check("hold", {23'd0, cout, result}, {23'd0, last_val});
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", {31'd0, ready}, 1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [8:0] e, input bit noisy);
    int n;
    wait_ready();
    op_a = a; op_b = b; cin = c; start = 1'b1;
    expq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("ready_drop", {31'd0, ready}, 0);
    check("busy_rise", {31'd0, busy}, 1);
    n = 1;
    while (!done && n < 40) begin
      if (noisy && n >= 3 && n <= 10) begin
        start = n[0];
        op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency", n, 17);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 0);
  endtask

  initial begin
    int n;
    logic [8:0] e;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    #12;
    check("rst_ready", {31'd0, ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_out", {23'd0, cout, result}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h00, 8'h00, 1'b0, 9'h000, 0);
    run_op(8'hFF, 8'h01, 1'b0, 9'h100, 0);
    run_op(8'h5A, 8'hA5, 1'b1, 9'h100, 0);
    run_op(8'h12, 8'h34, 1'b0, 9'h046, 0);
    run_op(8'h0F, 8'h01, 1'b0, 9'h010, 1);

    // Abandon an operation with an asynchronous reset; nothing is pushed.
    wait_ready();
    op_a = 8'h77; op_b = 8'h11; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out", {23'd0, cout, result}, 0);
    check("arst_done", {31'd0, done}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_ready", {31'd0, ready}, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h03, 8'h04, 1'b0, 9'h007, 0);

    // Back-to-back operations with start held high.
    b2b = 1;
    op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_ready();
      e = {1'b0, op_a} + {1'b0, op_b} + {8'd0, cin};
      expq.push_back(e);
      @(negedge clk);
      if (i == 19) start = 1'b0;
      else begin
        op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
      end
    end
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    b2b = 0;
    check("drain", expq.size(), 0);

`ifdef HA_SEQ_SUB_EN
    sub = 1'b1;
    run_op(8'h10, 8'h01, 1'b0, 9'h10F, 0);
    run_op(8'h01, 8'h02, 1'b0, 9'h0FF, 0);
    sub = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("final_queue", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
